// File: rtl/aprox_logit_if.sv
// Handshake bus for aprox_logit: probability in, logit estimate out.
// The master drives requests and out_ready. The slave (the logit core) returns ready/valid and results.
interface aprox_logit_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] p_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x_out;
  logic        sat;

  modport master (
    output in_valid, p_in, out_ready,
    input  in_ready, out_valid, x_out, sat
  );

  modport slave (
    input  in_valid, p_in, out_ready,
    output in_ready, out_valid, x_out, sat
  );
endinterface

// File: rtl/aprox_logit.sv
// Approximate logit of a Q8.8 probability: inverts the tail (0.5 - frac/4) * 2^-n
// by normalising min(p, 1-p) with one left shift per enabled clock.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// NORM  | doubling q until it exceeds 0x40, counting doublings in n
// DONE  | result held on x_out/sat until out_ready
module aprox_logit (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  aprox_logit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  q_q, q_d;
  logic [2:0]  n_q, n_d;
  logic        sign_q, sign_d;
  logic [15:0] x_q, x_d;
  logic        sat_q, sat_d;

  logic [7:0]  frac;
  logic [15:0] mag;

  // The binary weight of the remaining distance from 0.5, rescaled to Q8.8.
  assign frac = 8'((8'h80 - q_q) << 2);
  assign mag  = {5'b0, n_q, frac};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    n_d     = n_q;
    sign_d  = sign_q;
    x_d     = x_q;
    sat_d   = sat_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.p_in == 16'h0000) begin
              x_d     = 16'hF800;
              sat_d   = 1'b1;
              state_d = DONE;
            end else if (bus.p_in >= 16'h0100) begin
              x_d     = 16'h0800;
              sat_d   = 1'b1;
              state_d = DONE;
            end else begin
              sign_d  = (bus.p_in < 16'h0080);
              q_d     = (bus.p_in < 16'h0080) ? bus.p_in[7:0]
                                              : 8'(16'h0100 - bus.p_in);
              n_d     = 3'd0;
              sat_d   = 1'b0;
              state_d = NORM;
            end
          end
        end
        NORM: begin
          if (q_q <= 8'h40) begin
            q_d = q_q << 1;
            n_d = n_q + 3'd1;
          end else begin
            x_d     = sign_q ? (~mag + 16'd1) : mag;
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= 8'h00;
      n_q     <= 3'd0;
      sign_q  <= 1'b0;
      x_q     <= 16'h0000;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      n_q     <= n_d;
      sign_q  <= sign_d;
      x_q     <= x_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.x_out     = x_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_aprox_logit.sv
// Randomised and directed check of aprox_logit against an arithmetic model of the logit tail inversion.
module tb_aprox_logit;
  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  int   n_vec = 0;
  int   n_err = 0;

  aprox_logit_if bus ();

  aprox_logit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout global_time_limit");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The number of doublings is the count that lifts q above 0.25. For 1 <= q <= 128 this count equals 7 - ceil(log2 q).
  function automatic void model(input logic [15:0] p, output logic [15:0] x,
                                output logic s, output int lat);
    int q, n, mag;
    if (p == 16'h0000) begin
      x = 16'hF800; s = 1'b1; lat = 0;
    end else if (p >= 16'h0100) begin
      x = 16'h0800; s = 1'b1; lat = 0;
    end else begin
      q   = (p < 16'h0080) ? int'(p) : 256 - int'(p);
      n   = 7 - $clog2(q);
      mag = n * 256 + (128 - (q << n)) * 4;
      x   = (p < 16'h0080) ? 16'(-mag) : 16'(mag);
      s   = 1'b0;
      lat = n + 1;
    end
  endfunction

  // Latency counts enabled edges after the acceptance edge until out_valid is seen.
  task automatic run(input logic [15:0] p, input int stall_at, input int stall_len,
                     input int hold);
    logic [15:0] ex;
    logic        es;
    int          el, cnt;
    model(p, ex, es, el);
    cnt = 0;
    while (!bus.in_ready && cnt < 20) begin tick(); cnt++; end
    chk("in_ready_before_accept", {31'b0, bus.in_ready}, 32'd1);
    bus.p_in = p; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    bus.p_in = 16'($urandom);
    cnt = 0;
    while (!bus.out_valid && cnt < 30) begin
      if (cnt == stall_at) ena = 1'b0;
      if (cnt == stall_at + stall_len) ena = 1'b1;
      tick();
      cnt++;
      bus.p_in = 16'($urandom);
    end
    ena = 1'b1;
    chk($sformatf("latency p=%0h", p), cnt, el + stall_len);
    chk($sformatf("x_out p=%0h", p), {16'b0, bus.x_out}, {16'b0, ex});
    chk($sformatf("sat p=%0h", p), {31'b0, bus.sat}, {31'b0, es});
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.p_in = 16'($urandom);
      tick();
      chk("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("hold_x_out", {16'b0, bus.x_out}, {16'b0, ex});
      chk("hold_no_accept", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.p_in = 16'h00C0;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk("release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("release_out_valid", {31'b0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] directed [8];
    logic [15:0] pr;
    directed = '{16'h00C0, 16'h00A0, 16'h0020, 16'h0001,
                 16'h0080, 16'h0000, 16'h0100, 16'h1234};
    rst_n = 1'b0; ena = 1'b0;
    bus.in_valid = 1'b0; bus.p_in = 16'h0000; bus.out_ready = 1'b0;
    #1;
    chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset_x_out", {16'b0, bus.x_out}, 32'd0);
    chk("reset_sat", {31'b0, bus.sat}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    ena = 1'b1;

    foreach (directed[i]) run(directed[i], -1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      pr = (i % 8 == 7) ? 16'($urandom) : 16'($urandom_range(0, 257));
      run(pr, -1, 0, i % 3);
    end

    // The consumer stalls with new requests and a changing p_in pending.
    run(16'h0020, -1, 0, 5);

    // Removing the enable in the middle of normalisation delays completion without changing the result.
    run(16'h0001, 2, 3, 0);
    run(16'h00F7, 1, 3, 0);

    // With the enable low in IDLE, a valid request is not accepted.
    ena = 1'b0;
    bus.in_valid = 1'b1; bus.p_in = 16'h00A0;
    tick(); tick();
    chk("ena_low_no_accept", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b0;
    ena = 1'b1;

    // Reset taken in the middle of normalisation, between clock edges.
    bus.p_in = 16'h0001; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midnorm_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("midnorm_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("midnorm_rst_x_out", {16'b0, bus.x_out}, 32'd0);
    chk("midnorm_rst_sat", {31'b0, bus.sat}, 32'd0);
    rst_n = 1'b1;
    run(16'h00C0, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
